multicycle_ctrl: RTL and testbench



---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_imm_decode.sv | 30 +++
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle MIPS-subset controller.
//   - FSM state encoding (3 bits)
//   - primary opcode and funct constants
//   - ALU operation codes and datapath mux select codes
//   - op_supported(): opcodes this controller can sequence
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  // PC source select
  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;

  // ALU B input select
  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // Destination register select
  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_imm_decode.sv
// ctrl_imm_decode: combinational map from a latched opcode to the immediate
// extension mode and the ALU operation used in the execute step.
//   op        in   6  latched primary opcode
//   sign_ext  out  1  1 = sign-extend imm16, 0 = zero-extend
//   alu_op    out  3  ALU operation code (ctrl_pkg ALU_*)
module ctrl_imm_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  output logic       sign_ext,
  output logic [2:0] alu_op
);

  always_comb begin
    sign_ext = 1'b0;
    alu_op   = ALU_ADD;
    case (op)
      OP_R:                            alu_op = ALU_FUNCT;
      OP_BEQ, OP_BNE:                  alu_op = ALU_SUB;
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin sign_ext = 1'b1; alu_op = ALU_ADD; end
      OP_SLTI:                         begin sign_ext = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI:                         alu_op = ALU_AND;
      OP_ORI:                          alu_op = ALU_OR;
      OP_XORI:                         alu_op = ALU_XOR;
      OP_LUI:                          alu_op = ALU_LUI;
      default:                         alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the 32-bit MIPS-subset core.
// Steps one instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
// selects and write enables, handshakes with the shared memory and counts
// retired instructions.
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, funct         IR fields (opcode valid from DECODE onward)
//   alu_zero, mem_ready   ALU zero flag, memory access completion
//   mem_req/mem_we/iord   memory request, write strobe, address select
//   ir_we/pc_we/pc_src    IR and PC update controls
//   sign_ext/alu_src_a/alu_src_b/alu_op   ALU operand and operation selects
//   reg_we/reg_dst/wb_sel register file write controls
//   halted, retired       sticky halt flag, retired-instruction count
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit          RESET_STATE_FETCH = 1'b1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             sign_ext,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam state_e RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_HALT;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic imm_sign_ext;
  logic [2:0] imm_alu_op;
  logic retire;
  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;

  ctrl_imm_decode u_imm_decode (
    .op       (op_q),
    .sign_ext (imm_sign_ext),
    .alu_op   (imm_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      op_q      <= OP_R;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    iord      = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    pc_src    = PC_SRC_PC4;
    sign_ext  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = ALUB_RT;
    alu_op    = ALU_ADD;
    reg_we_c  = 1'b0;
    reg_dst   = RDST_RT;
    wb_sel    = WB_ALU;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end

      // DECODE looks at the live opcode; op_q only becomes valid afterwards.
      // The ALU speculatively forms the branch target into ALUOut here.
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        sign_ext  = 1'b1;
        if (opcode == OP_J || opcode == OP_JAL) begin
          pc_we_c = 1'b1;
          pc_src  = PC_SRC_JUMP;
          retire  = 1'b1;
          state_d = S_FETCH;
          if (opcode == OP_JAL) begin
            reg_we_c = 1'b1;
            reg_dst  = RDST_RA;
            wb_sel   = WB_PC;
          end
        end else if (opcode == OP_R && funct == FUNCT_SYSCALL) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (!op_supported(opcode)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        sign_ext  = imm_sign_ext;
        alu_op    = imm_alu_op;
        alu_src_b = (op_q == OP_R || op_q == OP_BEQ || op_q == OP_BNE) ? ALUB_RT : ALUB_IMM;
        if (op_q == OP_BEQ || op_q == OP_BNE) begin
          pc_we_c = (op_q == OP_BEQ) ? alu_zero : ~alu_zero;
          pc_src  = PC_SRC_BR;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        mem_we_c  = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = (op_q == OP_R) ? RDST_RD : RDST_RT;
        wb_sel   = (op_q == OP_LW) ? WB_MDR : WB_ALU;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

  assign op_d      = (state_q == S_DECODE) ? opcode : op_q;
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

  // Enables are qualified by rst_n so they drop the instant reset asserts,
  // even though the reset FETCH state would otherwise raise mem_req.
  assign mem_req = rst_n & mem_req_c;
  assign mem_we  = rst_n & mem_we_c;
  assign ir_we   = rst_n & ir_we_c;
  assign pc_we   = rst_n & pc_we_c;
  assign reg_we  = rst_n & reg_we_c;
  assign halted  = rst_n & (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        sign_ext, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        reg_we;
  logic [1:0]  reg_dst, wb_sel;
  logic        halted;
  logic [31:0] retired;

  multicycle_ctrl #(.RESET_STATE_FETCH(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .sign_ext(sign_ext), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        az;
    logic        rdy;
    logic [19:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t vt[$];
  int   n_pass = 0;
  int   n_total = 0;

  wire [19:0] act = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, sign_ext, alu_src_a,
                     alu_src_b, alu_op, reg_we, reg_dst, wb_sel, halted};
  wire [5:0]  act_en = {mem_req, mem_we, ir_we, pc_we, reg_we, halted};

  function automatic logic [19:0] o(input logic mr, mw, io, irw, pcw, input logic [1:0] ps,
                                    input logic se, sa, input logic [1:0] sb,
                                    input logic [2:0] aop, input logic rw,
                                    input logic [1:0] rd, ws, input logic h);
    return {mr, mw, io, irw, pcw, ps, se, sa, sb, aop, rw, rd, ws, h};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic az,
                     input logic rdy, input logic [19:0] e, input logic [31:0] r);
    vec_t v;
    v.op = op; v.fn = fn; v.az = az; v.rdy = rdy; v.exp = e; v.ret = r;
    vt.push_back(v);
  endtask

  // Advance one clock, then apply inputs and let combinational outputs settle.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; mem_ready = rdy;
    #1;
  endtask

  task automatic async_reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("async_reset_enables", {26'd0, act_en}, 32'd0);
    chk("async_reset_retired", retired, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  logic [19:0] F1, F0, DC, DC_JAL, DC_J, EX_ORI, EX_SEADD, EX_BEQ_T, EX_BNE_N;
  logic [19:0] EX_R, EX_LUI, MEM_LW, MEM_SW, WB_ALU, WB_R, WB_LW, HLT;

  initial begin
    // Hand-derived output vectors:
    //        mr mw io ir pc ps se sa sb op rw rd ws h
    F1       = o(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    F0       = o(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    DC       = o(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    DC_JAL   = o(0, 0, 0, 0, 1, 2, 1, 0, 3, 0, 1, 2, 2, 0);
    DC_J     = o(0, 0, 0, 0, 1, 2, 1, 0, 3, 0, 0, 0, 0, 0);
    EX_ORI   = o(0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
    EX_SEADD = o(0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    EX_BEQ_T = o(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    EX_BNE_N = o(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    EX_R     = o(0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0);
    EX_LUI   = o(0, 0, 0, 0, 0, 0, 0, 1, 2, 6, 0, 0, 0, 0);
    MEM_LW   = o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MEM_SW   = o(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    WB_ALU   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    WB_R     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    WB_LW    = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    HLT      = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // One entry per clock cycle: inputs applied in that cycle, expected outputs.
    // ori: 4 cycles to WB
    add(6'h0D, 6'h00, 0, 1, F1, 0);     add(6'h0D, 6'h00, 0, 1, DC, 0);
    add(6'h0D, 6'h00, 0, 1, EX_ORI, 0); add(6'h0D, 6'h00, 0, 1, WB_ALU, 0);
    // addi
    add(6'h08, 6'h00, 0, 1, F1, 1);     add(6'h08, 6'h00, 0, 1, DC, 1);
    add(6'h08, 6'h00, 0, 1, EX_SEADD, 1); add(6'h08, 6'h00, 0, 1, WB_ALU, 1);
    // lw, memory stalls three cycles in MEM
    add(6'h23, 6'h00, 0, 1, F1, 2);     add(6'h23, 6'h00, 0, 1, DC, 2);
    add(6'h23, 6'h00, 0, 1, EX_SEADD, 2);
    add(6'h23, 6'h00, 0, 0, MEM_LW, 2); add(6'h23, 6'h00, 0, 0, MEM_LW, 2);
    add(6'h23, 6'h00, 0, 0, MEM_LW, 2); add(6'h23, 6'h00, 0, 1, MEM_LW, 2);
    add(6'h23, 6'h00, 0, 1, WB_LW, 2);
    // beq taken (one fetch stall first)
    add(6'h04, 6'h00, 1, 0, F0, 3);     add(6'h04, 6'h00, 1, 1, F1, 3);
    add(6'h04, 6'h00, 1, 1, DC, 3);     add(6'h04, 6'h00, 1, 1, EX_BEQ_T, 3);
    // bne with zero set: not taken
    add(6'h05, 6'h00, 1, 1, F1, 4);     add(6'h05, 6'h00, 1, 1, DC, 4);
    add(6'h05, 6'h00, 1, 1, EX_BNE_N, 4);
    // sw
    add(6'h2B, 6'h00, 0, 1, F1, 5);     add(6'h2B, 6'h00, 0, 1, DC, 5);
    add(6'h2B, 6'h00, 0, 1, EX_SEADD, 5); add(6'h2B, 6'h00, 0, 1, MEM_SW, 5);
    // jal, j
    add(6'h03, 6'h00, 0, 1, F1, 6);     add(6'h03, 6'h00, 0, 1, DC_JAL, 6);
    add(6'h02, 6'h00, 0, 1, F1, 7);     add(6'h02, 6'h00, 0, 1, DC_J, 7);
    // R-type add
    add(6'h00, 6'h20, 0, 1, F1, 8);     add(6'h00, 6'h20, 0, 1, DC, 8);
    add(6'h00, 6'h20, 0, 1, EX_R, 8);   add(6'h00, 6'h20, 0, 1, WB_R, 8);
    // lui
    add(6'h0F, 6'h00, 0, 1, F1, 9);     add(6'h0F, 6'h00, 0, 1, DC, 9);
    add(6'h0F, 6'h00, 0, 1, EX_LUI, 9); add(6'h0F, 6'h00, 0, 1, WB_ALU, 9);
    // unsupported opcode: halt without retiring
    add(6'h3F, 6'h00, 0, 1, F1, 10);    add(6'h3F, 6'h00, 0, 1, DC, 10);
    add(6'h3F, 6'h00, 0, 1, HLT, 10);

    // Reset state (reset held low)
    #2;
    chk("reset_enables", {26'd0, act_en}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    #10;
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(posedge clk);
      #1;
      opcode = vt[i].op; funct = vt[i].fn; alu_zero = vt[i].az; mem_ready = vt[i].rdy;
      #1;
      $display("vec %0d op=%h rdy=%b out=%h exp=%h retired=%0d", i, vt[i].op, vt[i].rdy,
               act, vt[i].exp, retired);
      chk($sformatf("vec%0d_out", i), {12'd0, act}, {12'd0, vt[i].exp});
      chk($sformatf("vec%0d_retired", i), retired, vt[i].ret);
    end

    // HALT is sticky: 20 cycles with mem_ready toggling
    for (int c = 0; c < 20; c++) begin
      step(6'h00, 6'h00, c[0]);
      chk($sformatf("halt_hold%0d", c), {26'd0, act_en}, 32'h1);
      chk($sformatf("halt_retired%0d", c), retired, 32'd10);
    end
    $display("halt hold done retired=%0d halted=%b", retired, halted);

    // Reset pulse leaves HALT and returns to FETCH
    step(6'h00, 6'h00, 1'b0);
    async_reset_pulse();
    #1;
    chk("post_reset_fetch", {26'd0, act_en}, 32'h20);
    $display("reset pulse: mem_req=%b halted=%b retired=%0d", mem_req, halted, retired);

    // syscall retires and halts
    mem_ready = 1'b1; opcode = 6'h00; funct = 6'h0C;
    step(6'h00, 6'h0C, 1'b1);
    chk("syscall_decode", {26'd0, act_en}, 32'd0);
    step(6'h00, 6'h0C, 1'b1);
    chk("syscall_halted", {26'd0, act_en}, 32'h1);
    chk("syscall_retired", retired, 32'd1);
    $display("syscall: halted=%b retired=%0d", halted, retired);

    // sw with reset asserted mid-MEM
    step(6'h00, 6'h00, 1'b0);
    async_reset_pulse();
    mem_ready = 1'b1; opcode = 6'h2B; funct = 6'h00;
    step(6'h2B, 6'h00, 1'b1);          // DECODE
    step(6'h2B, 6'h00, 1'b1);          // EXEC
    step(6'h2B, 6'h00, 1'b0);          // MEM, memory not ready
    chk("sw_mem_stall", {26'd0, act_en}, 32'h30);
    chk("sw_mem_iord", {31'd0, iord}, 32'd1);
    step(6'h2B, 6'h00, 1'b0);          // still in MEM
    chk("sw_mem_hold", {26'd0, act_en}, 32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw_mid_mem_reset_req", {30'd0, mem_req, mem_we}, 32'd0);
    chk("sw_mid_mem_reset_retired", retired, 32'd0);
    $display("mid-MEM reset: mem_req=%b mem_we=%b retired=%0d", mem_req, mem_we, retired);
    #2;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
